// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR MAC that sweeps a coefficient memory against a circular sample history.
// One sample in, TAPS coefficient reads, then a rounded/saturated output held until accepted.
module fir_mac_sequencer #(
    parameter int TAPS        = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int ADDR_WIDTH  = 7,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   coeff_rd_en,
    output logic [ADDR_WIDTH-1:0]  coeff_rd_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   busy
);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1) << (OUT_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] OMAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OMIN = -OMAX - 1;

    typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, ROUND, OUT} state_t;

    state_t                        state_q;
    logic [ADDR_WIDTH-1:0]         cnt_q, wptr_q, addr_q, tap_d;
    logic                          rd_en_q, v_q, in_ready_q, busy_q, out_valid_q, out_sat_q;
    logic signed [DATA_WIDTH-1:0]  x_q, x2_q;
    logic signed [ACC_WIDTH-1:0]   acc_q, rnd_d, sh_d;
    logic signed [PW-1:0]          prod_d;
    logic [OUT_WIDTH-1:0]          out_data_q;
    logic [DATA_WIDTH-1:0]         hist [TAPS];

    always_comb begin
        tap_d  = wptr_q - addr_q - 1'b1;
        prod_d = $signed(coeff_rd_data) * x2_q;
        rnd_d  = acc_q + RND;
        sh_d   = rnd_d >>> OUT_SHIFT;
    end

    // History is a plain memory; CLEAR zeroes it, so it needs no reset of its own.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            hist[cnt_q] <= '0;
        else if (state_q == IDLE && in_valid && in_ready_q)
            hist[wptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            wptr_q      <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            v_q         <= 1'b0;
            x_q         <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            v_q  <= rd_en_q;
            x2_q <= x_q;
            if (v_q)
                acc_q <= acc_q + {{(ACC_WIDTH-PW){prod_d[PW-1]}}, prod_d};
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                IDLE: if (in_valid && in_ready_q) begin
                    state_q    <= MAC;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    acc_q      <= '0;
                    rd_en_q    <= 1'b1;
                    addr_q     <= '0;
                    x_q        <= in_data;
                end
                // Tap 0 is the sample just accepted; later taps walk backwards through history.
                MAC: if (addr_q == LAST) begin
                    rd_en_q <= 1'b0;
                    state_q <= DRAIN;
                end else begin
                    addr_q <= addr_q + 1'b1;
                    x_q    <= hist[tap_d];
                end
                DRAIN: state_q <= ROUND;
                ROUND: begin
                    out_valid_q <= 1'b1;
                    out_sat_q   <= (sh_d > OMAX) || (sh_d < OMIN);
                    out_data_q  <= sh_d > OMAX ? OMAX[OUT_WIDTH-1:0] :
                                   sh_d < OMIN ? OMIN[OUT_WIDTH-1:0] : sh_d[OUT_WIDTH-1:0];
                    state_q     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    wptr_q      <= wptr_q + 1'b1;
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign coeff_rd_en   = rd_en_q;
    assign coeff_rd_addr = addr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_sat       = out_sat_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed bench with a 1-cycle-latency coefficient memory model.
module tb_fir_mac_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, coeff_rd_en, out_valid, out_sat, busy;
    logic [15:0] in_data = '0, coeff_rd_data = '0, out_data;
    logic [6:0]  coeff_rd_addr;
    logic [15:0] coef [128];
    int checks = 0, failures = 0;
    int rd_cnt = 0, addr_bad = 0, rises = 0, hold_bad = 0;
    logic prev_en = 1'b0;

    fir_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coeff_rd_en(coeff_rd_en), .coeff_rd_addr(coeff_rd_addr), .coeff_rd_data(coeff_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coeff_rd_data <= coeff_rd_en ? coef[coeff_rd_addr] : 16'h0;

    always @(negedge clk) begin
        if (coeff_rd_en) begin
            if (coeff_rd_addr != 7'(rd_cnt)) addr_bad++;
            if (!prev_en) rises++;
            rd_cnt++;
        end
        prev_en = coeff_rd_en;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_coefs(input logic [15:0] all, input int idx, input logic [15:0] v);
        for (int i = 0; i < 128; i++) coef[i] = all;
        if (idx >= 0) coef[idx] = v;
    endtask

    task automatic push(input logic [15:0] x, input int hold, output logic [15:0] y,
                        output logic s, output int lat);
        int n = 0;
        rd_cnt = 0; addr_bad = 0; rises = 0; hold_bad = 0;
        y = '0; s = 1'b0; lat = -1;
        while (!in_ready && n < 400) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("in_ready_wait", in_ready, 1); return; end
        in_valid = 1'b1; in_data = x;
        @(negedge clk);
        in_valid = 1'b0; lat = 0;
        while (!out_valid && lat < 400) begin @(negedge clk); lat++; end
        if (!out_valid) begin chk("out_valid_wait", out_valid, 1); return; end
        y = out_data; s = out_sat;
        repeat (hold) begin
            @(negedge clk);
            if (out_data != y || out_sat != s || in_ready || coeff_rd_en || !out_valid) hold_bad++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (hold > 0) begin
            chk("hold_stable", hold_bad, 0);
            chk("ready_after_accept", in_ready, 1);
            chk("valid_after_accept", out_valid, 0);
        end
    endtask

    task automatic clear_len(input string tag);
        int n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk(tag, n, 128);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic impulse(input int n, input string tag);
        logic [15:0] y, y64;
        logic s;
        int lat, bad, sats;
        bad = 0; sats = 0; y64 = '0;
        set_coefs(16'h0, 64, 16'h7FFF);
        for (int i = 0; i < n; i++) begin
            push(i == 0 ? 16'h4000 : 16'h0000, 0, y, s, lat);
            if (i == 0) begin
                chk({tag, "_latency"}, lat, 130);
                chk({tag, "_rd_count"}, rd_cnt, 128);
                chk({tag, "_rd_order"}, addr_bad, 0);
                chk({tag, "_rd_runs"}, rises, 1);
            end
            if (i == 64) y64 = y;
            else if (y != 16'h0) bad++;
            if (s) sats++;
        end
        chk({tag, "_y64"}, y64, 16'h4000);
        chk({tag, "_others_zero"}, bad, 0);
        chk({tag, "_no_sat"}, sats, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] y;
        logic s;
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rd_en", coeff_rd_en, 0);
        chk("rst_rd_addr", coeff_rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 1);
        rst_n = 1'b1;
        clear_len("clear1");

        impulse(140, "imp1");

        set_coefs(16'h7FFF, -1, 16'h0);
        push(16'h7FFF, 0, y, s, lat);
        chk("max_first_y", y, 16'h7FFE);
        chk("max_first_sat", s, 0);
        for (int i = 1; i < 128; i++) push(16'h7FFF, 0, y, s, lat);
        chk("pos_sat_y", y, 16'h7FFF);
        chk("pos_sat_flag", s, 1);
        for (int i = 0; i < 128; i++) push(16'h8000, 0, y, s, lat);
        chk("neg_sat_y", y, 16'h8000);
        chk("neg_sat_flag", s, 1);

        set_coefs(16'h0, 0, 16'h0001);
        push(16'h4000, 0, y, s, lat);
        chk("round_half_up", y, 16'h0001);
        push(16'hC000, 0, y, s, lat);
        chk("round_neg_half", y, 16'h0000);
        push(16'hBFFF, 0, y, s, lat);
        chk("round_neg_below", y, 16'hFFFF);
        chk("round_no_sat", s, 0);

        set_coefs(16'h0, 0, 16'h4000);
        push(16'h2000, 10, y, s, lat);
        chk("bp_y", y, 16'h1000);
        chk("bp_rd_count", rd_cnt, 128);

        set_coefs(16'h1234, -1, 16'h0);
        in_valid = 1'b1; in_data = 16'h7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_rd_en_before", coeff_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_rd_en", coeff_rd_en, 0);
        chk("mid_rst_rd_addr", coeff_rd_addr, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_len("clear2");
        impulse(70, "imp2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
